kmap_lut_seq: RTL and testbench

- Registered, runtime-programmable truth-table evaluator; successor to the fixed 4-input/3-output K-map logic block.
- Generalised to N_IN inputs and N_OUT outputs, with a per-minterm don't-care mask and a selectable don't-care fill policy.
- Table is loaded through a write port. Evaluation runs either as single lookups (valid/ready) or as an automatic full-minterm sweep (start/busy/done FSM).
- Used by logic-minimisation exercises and their self-checking benches.

---
 rtl/kmap_lut_seq.sv | 163 ++++++++++++++++
 tb/tb_kmap_lut_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kmap_lut_seq.sv
// kmap_lut_seq: registered, runtime-programmable truth-table evaluator.
// Each of the 2^N_IN entries holds N_OUT function bits plus N_OUT don't-care
// flags. Results come from single lookups (in_valid/in_ready) or from an
// automatic ascending sweep of every minterm (sweep_start/busy/done).
//
// Handshake: a lookup (in_valid) or table write (cfg_we) is accepted on a
// rising edge where in_ready/cfg_ready (both equal !busy) is high. There is
// no backpressure on the result side. out_valid pulses for one cycle per
// result. out_idx/out_f/out_dc hold between results.
//
// Optional build macro KMAP_LUT_PARITY_EN: stores an even-parity bit per
// entry, adds cfg_par_inv (fault injection) and a sticky par_err output.
module kmap_lut_seq #(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 3,
    parameter int DC_FILL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_f,
    input  logic [N_OUT-1:0] cfg_dc,
    output logic             cfg_ready,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             in_ready,
    input  logic             sweep_start,
`ifdef KMAP_LUT_PARITY_EN
    input  logic             cfg_par_inv,
    output logic             par_err,
`endif
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    output logic [N_IN-1:0]  out_idx,
    output logic [N_OUT-1:0] out_f,
    output logic [N_OUT-1:0] out_dc
);

    localparam int              DEPTH    = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);
    localparam logic            FILL     = (DC_FILL != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [N_IN-1:0]   cnt;

    logic [N_OUT-1:0]  tab_f  [DEPTH];
    logic [N_OUT-1:0]  tab_dc [DEPTH];

    logic              accept_lookup;
    logic              write_en;
    logic              read_en;
    logic [N_IN-1:0]   read_addr;
    logic [N_OUT-1:0]  rd_f;
    logic [N_OUT-1:0]  rd_dc;
    logic [N_OUT-1:0]  res_f;

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign cfg_ready     = !busy;
    assign in_ready      = !busy;
    assign accept_lookup = in_valid && !busy;
    assign write_en      = cfg_we && !busy;
    // The sweep owns the read port while in SWEEP; otherwise lookups use it.
    assign read_en       = accept_lookup || (state == SWEEP);
    assign read_addr     = (state == SWEEP) ? cnt : in_vec;
    assign rd_f          = tab_f[read_addr];
    assign rd_dc         = tab_dc[read_addr];
    // Don't-care bits are replaced by the fill value; the rest pass through.
    assign res_f         = (rd_f & ~rd_dc) | (rd_dc & {N_OUT{FILL}});

    // State register and sweep counter; reset aborts any sweep in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && sweep_start) begin
                cnt <= '0;
            end else if (state == SWEEP) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next-state logic: IDLE -> SWEEP on start, SWEEP ends after the last index.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sweep_start) state_next = SWEEP;
            SWEEP:   if (cnt == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Table storage; the read above sees the pre-write contents (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_f[i]  <= '0;
                tab_dc[i] <= '0;
            end
        end else if (write_en) begin
            tab_f[cfg_addr]  <= cfg_f;
            tab_dc[cfg_addr] <= cfg_dc;
        end
    end

    // Result register: one-cycle latency, holds data when nothing is read.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_f     <= '0;
            out_dc    <= '0;
        end else begin
            out_valid <= read_en;
            if (read_en) begin
                out_idx <= read_addr;
                out_f   <= res_f;
                out_dc  <= rd_dc;
            end
        end
    end

`ifdef KMAP_LUT_PARITY_EN
    logic tab_p [DEPTH];
    logic rd_p;

    assign rd_p = tab_p[read_addr];

    // Parity store: even parity over {f,dc}, optionally inverted to inject a fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_p[i] <= 1'b0;
            end
        end else if (write_en) begin
            tab_p[cfg_addr] <= (^{cfg_f, cfg_dc}) ^ cfg_par_inv;
        end
    end

    // Sticky error flag: any read whose {f,dc,p} has odd weight sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (read_en && (^{rd_f, rd_dc, rd_p})) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_kmap_lut_seq.sv
// tb_kmap_lut_seq: randomized bench for kmap_lut_seq (N_IN=4, N_OUT=3,
// DC_FILL=1) against a truth-table reference model held in plain arrays.
module tb_kmap_lut_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int DEPTH = 16;
    localparam bit FILL  = 1'b1;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [N_IN-1:0]  cfg_addr;
    logic [N_OUT-1:0] cfg_f;
    logic [N_OUT-1:0] cfg_dc;
    logic             cfg_ready;
    logic             in_valid;
    logic [N_IN-1:0]  in_vec;
    logic             in_ready;
    logic             sweep_start;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic [N_IN-1:0]  out_idx;
    logic [N_OUT-1:0] out_f;
    logic [N_OUT-1:0] out_dc;
`ifdef KMAP_LUT_PARITY_EN
    logic             cfg_par_inv;
    logic             par_err;
`endif

    kmap_lut_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DC_FILL(1)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_f(cfg_f), .cfg_dc(cfg_dc),
        .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
        .sweep_start(sweep_start),
`ifdef KMAP_LUT_PARITY_EN
        .cfg_par_inv(cfg_par_inv), .par_err(par_err),
`endif
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_idx(out_idx), .out_f(out_f), .out_dc(out_dc)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the truth table as the user wrote it.
    logic [N_OUT-1:0] mf  [DEPTH];
    logic [N_OUT-1:0] mdc [DEPTH];
    logic [N_OUT-1:0] last_f;
    logic [N_OUT-1:0] last_dc;
    logic [N_IN-1:0]  last_idx;

    // Scoreboard
    logic [N_IN+2*N_OUT-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N_OUT-1:0] model_f(input int idx);
        logic [N_OUT-1:0] r;
        for (int i = 0; i < N_OUT; i++) r[i] = mdc[idx][i] ? FILL : mf[idx][i];
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mf[i]  = '0;
            mdc[i] = '0;
        end
        last_f = '0; last_dc = '0; last_idx = '0;
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_write(input int a, input logic [N_OUT-1:0] f, input logic [N_OUT-1:0] dc);
        cfg_we = 1'b1; cfg_addr = N_IN'(a); cfg_f = f; cfg_dc = dc;
        step();
        cfg_we = 1'b0;
        mf[a] = f; mdc[a] = dc;
    endtask

    task automatic check_result(input string tag, input int idx);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_idx"},   32'(out_idx),   32'(idx));
        check({tag, "_f"},     32'(out_f),     32'(model_f(idx)));
        check({tag, "_dc"},    32'(out_dc),    32'(mdc[idx]));
        last_f = model_f(idx); last_dc = mdc[idx]; last_idx = N_IN'(idx);
    endtask

    task automatic do_lookup(input string tag, input int idx);
        in_valid = 1'b1; in_vec = N_IN'(idx);
        step();
        in_valid = 1'b0;
        check_result(tag, idx);
    endtask

    task automatic idle_cycle();
        step();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_hold_f", 32'(out_f), 32'(last_f));
        check("idle_hold_idx", 32'(out_idx), 32'(last_idx));
    endtask

    // Full sweep with random writes/lookups thrown at the busy block.
    task automatic run_sweep();
        logic [N_IN+2*N_OUT-1:0] e;
        for (int k = 0; k < DEPTH; k++) exp_q.push_back({N_IN'(k), model_f(k), mdc[k]});
        sweep_start = 1'b1;
        step();  // T0
        sweep_start = 1'b0;
        check("sw_busy_t1", 32'(busy), 32'd1);
        check("sw_ready_t1", 32'({in_ready, cfg_ready}), 32'd0);
        check("sw_nvalid_t1", 32'(out_valid), 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_vec   = N_IN'($urandom_range(0, DEPTH - 1));
            cfg_we   = 1'($urandom_range(0, 1));
            cfg_addr = N_IN'($urandom_range(0, DEPTH - 1));
            cfg_f    = N_OUT'($urandom);
            cfg_dc   = N_OUT'($urandom);
            sweep_start = 1'($urandom_range(0, 1));
            step();
            e = exp_q.pop_front();
            check("sw_valid", 32'(out_valid), 32'd1);
            check("sw_busy", 32'(busy), 32'd1);
            check("sw_done", 32'(done), 32'(k == DEPTH - 1));
            check("sw_result", 32'({out_idx, out_f, out_dc}), 32'(e));
        end
        in_valid = 1'b0; cfg_we = 1'b0; sweep_start = 1'b0;
        step();
        check("sw_end_busy", 32'(busy), 32'd0);
        check("sw_end_done", 32'(done), 32'd0);
        check("sw_end_valid", 32'(out_valid), 32'd0);
        last_f = model_f(DEPTH - 1); last_dc = mdc[DEPTH - 1]; last_idx = N_IN'(DEPTH - 1);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_f = '0; cfg_dc = '0;
        in_valid = 1'b0; in_vec = '0; sweep_start = 1'b0;
`ifdef KMAP_LUT_PARITY_EN
        cfg_par_inv = 1'b0;
`endif
        model_clear();

        // Reset: state and every entry cleared
        do_reset(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'({out_idx, out_f, out_dc}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_ready", 32'({in_ready, cfg_ready}), 32'b11);
        for (int i = 0; i < DEPTH; i++) begin
            do_lookup("rst_lk", i);
            check("rst_lk_bd", 32'({busy, done}), 32'd0);
        end

        // Directed don't-care resolution
        do_write(5, 3'b010, 3'b100);
        do_lookup("dc5", 5);
        check("dc5_f_const", 32'(out_f), 32'b110);
        idle_cycle();

        // Random table loads and lookups
        for (int n = 0; n < 40; n++) do_write($urandom_range(0, DEPTH - 1), N_OUT'($urandom), N_OUT'($urandom));
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            else do_lookup("rnd_lk", $urandom_range(0, DEPTH - 1));
        end

        // Collision: lookup returns the old entry, next lookup the new one
        do_write(3, 3'b000, 3'b000);
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_f = 3'b111; cfg_dc = 3'b000;
        in_valid = 1'b1; in_vec = 4'd3;
        step();
        cfg_we = 1'b0; in_valid = 1'b0;
        check("coll_old_f", 32'(out_f), 32'b000);
        mf[3] = 3'b111;
        do_lookup("coll_new", 3);

        // Sweeps (second one after fresh random content)
        run_sweep();
        for (int n = 0; n < 10; n++) do_write($urandom_range(0, DEPTH - 1), N_OUT'($urandom), N_OUT'($urandom));
        run_sweep();
        do_lookup("post_sweep", $urandom_range(0, DEPTH - 1));

        // Lookup and sweep start together: lookup served, sweep starts
        in_valid = 1'b1; in_vec = 4'd9; sweep_start = 1'b1;
        step();
        in_valid = 1'b0; sweep_start = 1'b0;
        check_result("both_lk", 9);
        check("both_busy", 32'(busy), 32'd1);
        repeat (DEPTH + 1) step();
        check("both_end_busy", 32'(busy), 32'd0);

        // Mid-sweep reset at index 7
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int k = 0; k <= 7; k++) step();
        check("mid_idx7", 32'(out_idx), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 12; k++) begin
            step();
            check("mid_no_done", 32'(done), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) do_lookup("mid_clr", i);

`ifdef KMAP_LUT_PARITY_EN
        check("par_clean", 32'(par_err), 32'd0);
        cfg_par_inv = 1'b1;
        do_write(9, 3'b011, 3'b001);
        cfg_par_inv = 1'b0;
        check("par_not_yet", 32'(par_err), 32'd0);
        do_lookup("par_lk", 9);
        check("par_set", 32'(par_err), 32'd1);
        for (int n = 0; n < 4; n++) begin
            do_lookup("par_clean_lk", $urandom_range(0, 8));
            check("par_sticky", 32'(par_err), 32'd1);
        end
        do_reset(1);
        check("par_rst", 32'(par_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
